// File: rtl/jtcps1_line_sched.sv
// Per-scanline render scheduler: runs the OBJ/SCR1/SCR2/SCR3 engines one at a
// time on each line-start edge and lends the shared GFX ROM port to the active one.
module jtcps1_line_sched #(
  parameter int AW = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [8:0]      vrender,
  input  logic [3:0]      layer_en,
  output logic [8:0]      line,
  output logic [3:0]      go,
  input  logic [3:0]      done,
  output logic            busy,
  output logic            line_done,
  output logic            overrun,
  output logic [7:0]      ovr_cnt,
  input  logic [4*AW-1:0] lyr_addr,
  input  logic [3:0]      lyr_cs,
  output logic [3:0]      lyr_ok,
  output logic [AW-1:0]   rom_addr,
  output logic            rom_cs,
  input  logic            rom_ok
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0] state;
  logic [1:0] cur;
  logic [3:0] pending;
  logic       start_d;
  logic       ld_q;

  logic       start_edge;
  logic       cur_done;
  logic [3:0] pend_nx;
  logic       ovr_hit;
  logic       fin_now;

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0])      lowest = 2'd0;
    else if (v[1]) lowest = 2'd1;
    else if (v[2]) lowest = 2'd2;
    else           lowest = 2'd3;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] k);
    onehot = 4'b0001 << k;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A done arriving together with the start edge is applied before deciding
  // whether the old line was cut short.
  always_comb begin
    start_edge = start & ~start_d;
    cur_done   = (state == RUN) && done[cur];
    pend_nx    = cur_done ? (pending & ~onehot(cur)) : pending;
    ovr_hit    = start_edge && (pend_nx != 4'd0);
    fin_now    = start_edge && cur_done && (pend_nx == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur     <= 2'd0;
      pending <= 4'd0;
      start_d <= 1'b0;
      ld_q    <= 1'b0;
      overrun <= 1'b0;
      ovr_cnt <= 8'd0;
      line    <= 9'd0;
    end else begin
      start_d <= start;
      ld_q    <= 1'b0;
      overrun <= 1'b0;
      if (start_edge) begin
        line    <= vrender;
        pending <= layer_en;
        cur     <= lowest(layer_en);
        ld_q    <= (layer_en == 4'd0) | fin_now;
        overrun <= ovr_hit;
        if (ovr_hit) ovr_cnt <= sat_inc(ovr_cnt);
        // After an abort the new line goes through GAP so go stays low a cycle.
        if (layer_en == 4'd0) state <= IDLE;
        else if (ovr_hit)     state <= GAP;
        else                  state <= RUN;
      end else begin
        case (state)
          RUN: begin
            if (done[cur]) begin
              pending <= pend_nx;
              state   <= GAP;
            end
          end
          GAP: begin
            if (pending != 4'd0) begin
              cur   <= lowest(pending);
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

  // ROM port mux and run request follow the state register directly.
  always_comb begin
    go       = 4'd0;
    rom_addr = '0;
    rom_cs   = 1'b0;
    lyr_ok   = 4'd0;
    if (state == RUN) begin
      go          = onehot(cur);
      rom_addr    = lyr_addr[int'(cur)*AW +: AW];
      rom_cs      = lyr_cs[cur];
      lyr_ok[cur] = rom_ok;
    end
  end

  assign busy      = (state != IDLE);
  assign line_done = ld_q | ((state == GAP) && (pending == 4'd0));

endmodule

// File: doc/jtcps1_line_sched.md
Name: jtcps1_line_sched

Overview:
Per-scanline render scheduler for the CPS1 video pipeline. On each line-start strobe from the video timing generator it latches the render line number and runs up to four layer render engines one at a time. Layer order is index 0 to 3: OBJ, SCR1, SCR2, SCR3. While a layer runs, that layer owns the single shared GFX ROM port; the block muxes the port to it. The block detects lines whose rendering did not finish before the next strobe and counts them.

Parameters:
AW, 20, GFX ROM address width in bits.

Ports:
clk  input  1  system clock
rst  input  1  reset
start  input  1  line-start level from timing; high for one cen8 period, so possibly several clk cycles
vrender  input  9  line to render, valid when start is high
layer_en  input  4  per-layer enable, sampled at the start edge
line  output  9  latched render line, fed to the engines
go  output  4  one-hot run request, held high until the engine signals done
done  input  4  per-layer completion, level or pulse
busy  output  1  high while any layer of the current line is pending or running
line_done  output  1  one-clk pulse when all enabled layers for the line have completed
overrun  output  1  one-clk pulse when a line is aborted by a new start edge
ovr_cnt  output  8  saturating count of overruns
lyr_addr  input  4*AW  engine ROM addresses; layer k occupies bits [k*AW +: AW]
lyr_cs  input  4  engine ROM chip-selects
lyr_ok  output  4  per-engine ROM data valid
rom_addr  output  AW  shared ROM address
rom_cs  output  1  shared ROM chip-select
rom_ok  input  1  shared ROM data valid

Behaviour:
- Reset is asynchronous and active-high on rst, with clock clk.
- Values at reset: go=0, busy=0, line_done=0, overrun=0, ovr_cnt=0, line=0, rom_cs=0, rom_addr=0, lyr_ok=0, state=IDLE, pending=0.
- Start edge detection: start_edge = start & ~start_d, where start_d is start registered every clk. Only the edge acts; the remaining high cycles are ignored.
- States: IDLE, RUN, GAP.
- Start edge, any state:
  - line <= vrender.
  - pending <= layer_en.
  - If layer_en==0: line_done pulses next cycle and state=IDLE.
  - Otherwise: state=RUN on the lowest set bit k; go[k] goes high on the cycle after the edge (latency 1).
- RUN(k):
  - go = one-hot k.
  - rom_addr = lyr_addr[k]; rom_cs = lyr_cs[k]; lyr_ok[k] = rom_ok; all other lyr_ok bits = 0. The mux is combinational from the state register.
  - done[k] high: clear pending[k]; go drops on the next cycle; state=GAP.
  - done on a non-active index is ignored.
- GAP: exactly one cycle with go=0 and rom_cs=0, so engines see go fall before the next layer starts.
  - If pending!=0: RUN on the lowest pending bit. The next go rises two cycles after the done cycle.
  - Otherwise: line_done pulses in that GAP cycle; state=IDLE.
- IDLE: go=0, rom_cs=0, rom_addr=0, lyr_ok=0.
- busy = (state!=IDLE).
- Overrun: a start edge arrives while busy, after done in that same cycle is applied.
  - Current go is dropped; engines treat go falling as abort.
  - overrun pulses; ovr_cnt += 1, saturating at 255.
  - The new line starts per the start-edge rule, but the first go is delayed one extra cycle (go low for one cycle) so the abort is always visible.
- Simultaneous done[k] and start edge:
  - k is the last pending layer: the line counts as completed. line_done pulses, there is no overrun, and the new line starts normally.
  - Otherwise: overrun.
- Changes to layer_en mid-line have no effect until the next start edge.
- rst mid-operation returns everything to reset values immediately, including ovr_cnt.

Test Plan:
- layer_en=4'b1111, vrender=9'h20, each engine asserts done 10 cycles after its go → go sequence 0001,0010,0100,1000; each go rises 2 cycles after the previous done; line_done once; line=9'h20; overrun=0.
- layer_en=4'b1010 → only go[1] then go[3]; rom_addr follows lyr_addr[1], then lyr_addr[3]; lyr_ok[0]/[2] stay 0 while rom_ok toggles.
- layer_en=0 at start edge → line_done pulse 1 cycle after the edge; go never rises; busy stays 0.
- Engine 2 never asserts done; next start edge with vrender=9'h21 → go[2] falls, overrun pulses, ovr_cnt=1, go[0] rises 2 cycles after the edge, line=9'h21.
- done[3] as the last layer coincides with the start edge → line_done=1, overrun=0, ovr_cnt unchanged.
- 300 consecutive overruns → ovr_cnt saturates at 8'd255; rst asserted mid-RUN → all outputs return to reset values asynchronously.
